// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_param
// Description : Parametrised SPI master. Configurable word width, SCLK
//               divider, bit order and chip-select count; SPI mode
//               (CPOL/CPHA) is latched per transaction. Start/done handshake
//               on the host side, fully registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 3,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int NUM_SLAVES = 1,
  parameter int SEL_W      = 1
) (
  input  logic                  clk,
  input  logic                  i_reset_n,   // synchronous, active-low
  input  logic                  i_start,
  input  logic [SEL_W-1:0]      i_slave_sel,
  input  logic [1:0]            i_mode,      // {CPOL, CPHA}
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sclk,
  output logic [NUM_SLAVES-1:0] o_cs,
  output logic                  o_mosi,
  input  logic                  i_miso
);

  localparam int                    c_DIV_W     = $clog2(CLK_DIV);
  localparam int                    c_EDGE_W    = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [c_DIV_W-1:0]    c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_EDGE_W-1:0]   c_EDGE_LAST = c_EDGE_W'(2 * DATA_WIDTH);
  localparam logic [NUM_SLAVES-1:0] c_CS_ONE    = NUM_SLAVES'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_DIV_W-1:0]    r_div;
  logic [c_EDGE_W-1:0]   r_edge;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [1:0]            r_mode;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;
  logic [NUM_SLAVES-1:0] r_cs;

  logic                  w_sel_ok;
  logic                  w_in_first;
  logic [DATA_WIDTH-1:0] w_in_shift;
  logic                  w_tx_bit;
  logic [DATA_WIDTH-1:0] w_tx_shift;
  logic [DATA_WIDTH-1:0] w_rx_shift;
  logic                  w_div_wrap;
  logic [c_EDGE_W-1:0]   w_edge_next;
  logic                  w_last_edge;
  logic                  w_sample;

  // Out-of-range slave indices are never accepted.
  assign w_sel_ok    = (32'(i_slave_sel) < 32'(NUM_SLAVES));

  // Bit-order dependent selection of the next MOSI bit and shift directions.
  assign w_in_first  = LSB_FIRST ? i_tx_data[0] : i_tx_data[DATA_WIDTH-1];
  assign w_in_shift  = LSB_FIRST ? {1'b0, i_tx_data[DATA_WIDTH-1:1]}
                                 : {i_tx_data[DATA_WIDTH-2:0], 1'b0};
  assign w_tx_bit    = LSB_FIRST ? r_tx[0] : r_tx[DATA_WIDTH-1];
  assign w_tx_shift  = LSB_FIRST ? {1'b0, r_tx[DATA_WIDTH-1:1]}
                                 : {r_tx[DATA_WIDTH-2:0], 1'b0};
  assign w_rx_shift  = LSB_FIRST ? {i_miso, r_rx[DATA_WIDTH-1:1]}
                                 : {r_rx[DATA_WIDTH-2:0], i_miso};

  assign w_div_wrap  = (r_div == c_DIV_LAST);
  assign w_edge_next = r_edge + 1'b1;
  assign w_last_edge = (w_edge_next == c_EDGE_LAST);
  // Odd edges are leading; CPHA=0 samples on leading, CPHA=1 on trailing.
  assign w_sample    = w_edge_next[0] ^ r_mode[0];

  // Transaction sequencer: owns every registered output.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_edge    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_mode    <= 2'b00;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cs      <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && w_sel_ok) begin
            r_state <= S_SETUP;
            r_busy  <= 1'b1;
            r_cs    <= ~(c_CS_ONE << i_slave_sel);
            r_mode  <= i_mode;
            r_sclk  <= i_mode[1];
            r_div   <= '0;
            r_edge  <= '0;
            // CPHA=0 presents the first bit before the first SCLK edge.
            if (!i_mode[0]) begin
              r_mosi <= w_in_first;
              r_tx   <= w_in_shift;
            end else begin
              r_tx   <= i_tx_data;
            end
          end
        end
        // SETUP and XFER share the edge logic: the SETUP wrap is edge 1.
        S_SETUP, S_XFER: begin
          if (w_div_wrap) begin
            r_div   <= '0;
            r_sclk  <= ~r_sclk;
            r_edge  <= w_edge_next;
            r_state <= w_last_edge ? S_HOLD : S_XFER;
            if (w_sample) begin
              r_rx <= w_rx_shift;
            end else if (!w_last_edge) begin
              r_mosi <= w_tx_bit;
              r_tx   <= w_tx_shift;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_div_wrap) begin
            r_div     <= '0;
            r_state   <= S_IDLE;
            r_cs      <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_sclk    <= r_mode[1];
            r_rx_data <= r_rx;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rx_data = r_rx_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_sclk    = r_sclk;
  assign o_cs      = r_cs;
  assign o_mosi    = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_param
// Description : Directed self-checking bench for spi_master_param. Instance A
//               is 8-bit LSB-first single-slave, instance B is 16-bit
//               MSB-first with four chip selects. Behavioural slaves answer
//               each instance with a programmed word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: W=8, CLK_DIV=3, LSB first, one slave
  logic       a_start = 1'b0;
  logic [0:0] a_sel = 1'b0;
  logic [1:0] a_mode = 2'b00;
  logic [7:0] a_tx = 8'h00;
  logic [7:0] a_rx;
  logic       a_busy, a_done, a_sclk, a_mosi;
  logic [0:0] a_cs;
  logic       a_miso = 1'b0;

  spi_master_param #(.DATA_WIDTH(8), .CLK_DIV(3), .LSB_FIRST(1'b1),
                     .NUM_SLAVES(1), .SEL_W(1)) u_a (
    .clk(clk), .i_reset_n(rst_n), .i_start(a_start), .i_slave_sel(a_sel),
    .i_mode(a_mode), .i_tx_data(a_tx), .o_rx_data(a_rx), .o_busy(a_busy),
    .o_done(a_done), .o_sclk(a_sclk), .o_cs(a_cs), .o_mosi(a_mosi),
    .i_miso(a_miso));

  // Instance B: W=16, CLK_DIV=3, MSB first, four slaves
  logic        b_start = 1'b0;
  logic [2:0]  b_sel = 3'd0;
  logic [1:0]  b_mode = 2'b00;
  logic [15:0] b_tx = 16'h0000;
  logic [15:0] b_rx;
  logic        b_busy, b_done, b_sclk, b_mosi;
  logic [3:0]  b_cs;
  logic        b_miso = 1'b0;

  spi_master_param #(.DATA_WIDTH(16), .CLK_DIV(3), .LSB_FIRST(1'b0),
                     .NUM_SLAVES(4), .SEL_W(3)) u_b (
    .clk(clk), .i_reset_n(rst_n), .i_start(b_start), .i_slave_sel(b_sel),
    .i_mode(b_mode), .i_tx_data(b_tx), .o_rx_data(b_rx), .o_busy(b_busy),
    .o_done(b_done), .o_sclk(b_sclk), .o_cs(b_cs), .o_mosi(b_mosi),
    .i_miso(b_miso));

  // Slave A: any mode, LSB first; sa_got[i] is the i-th MOSI bit received
  logic [7:0] sa_word = 8'h00;
  logic [7:0] sa_got = 8'h00;
  int         sa_cnt = 0;
  int         sa_rise = 0;
  logic       sa_prev_act = 1'b0;
  logic       sa_prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (a_cs == 1'b0 && !sa_prev_act) begin
      sa_cnt = 0; sa_rise = 0; sa_got = 8'h00;
      if (!a_mode[0]) a_miso = sa_word[0];
    end else if (a_cs == 1'b0 && a_sclk != sa_prev_sclk) begin
      if (a_sclk) sa_rise++;
      if (!a_mode[0]) begin
        if (a_sclk != a_mode[1]) begin
          if (sa_cnt < 8) sa_got[sa_cnt] = a_mosi;
        end else begin
          sa_cnt++;
          if (sa_cnt < 8) a_miso = sa_word[sa_cnt];
        end
      end else begin
        if (a_sclk != a_mode[1]) begin
          if (sa_cnt < 8) a_miso = sa_word[sa_cnt];
        end else begin
          if (sa_cnt < 8) sa_got[sa_cnt] = a_mosi;
          sa_cnt++;
        end
      end
    end
    sa_prev_act  = (a_cs == 1'b0);
    sa_prev_sclk = a_sclk;
  end

  // Slave B: mode 0, MSB first; sb_seq shifts in MOSI so it equals the word sent
  logic [15:0] sb_word = 16'h0000;
  logic [15:0] sb_seq = 16'h0000;
  int          sb_cnt = 0;
  logic        sb_prev_act = 1'b0;
  logic        sb_prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (b_cs != 4'hF && !sb_prev_act) begin
      sb_cnt = 0; sb_seq = 16'h0000; b_miso = sb_word[15];
    end else if (b_cs != 4'hF && b_sclk != sb_prev_sclk) begin
      if (b_sclk) sb_seq = {sb_seq[14:0], b_mosi};
      else begin
        sb_cnt++;
        if (sb_cnt < 16) b_miso = sb_word[15 - sb_cnt];
      end
    end
    sb_prev_act  = (b_cs != 4'hF);
    sb_prev_sclk = b_sclk;
  end

  // Results of the last run_a frame
  int         fb, dc;
  logic       sclk_pre, sclk_e1, sclk_idle, done_after;
  logic [7:0] rx_mid;

  // Runs one frame on A (called at a negedge); records timing, no checks.
  task automatic run_a(input logic [7:0] tx, input logic [1:0] mode, input logic [7:0] word);
    a_tx = tx; a_mode = mode; sa_word = word; a_start = 1'b1;
    fb = -1; dc = -1; sclk_pre = 1'bx; sclk_e1 = 1'bx; rx_mid = 8'hxx;
    for (int i = 0; i < 300 && dc < 0; i++) begin
      @(negedge clk);
      if (a_busy && fb < 0) begin fb = cyc; a_start = 1'b0; end
      if (fb >= 0 && cyc == fb + 2) sclk_pre = a_sclk;
      if (fb >= 0 && cyc == fb + 3) sclk_e1 = a_sclk;
      if (fb >= 0 && cyc == fb + 20) rx_mid = a_rx;
      if (a_done) dc = cyc;
    end
    a_start = 1'b0;
    @(negedge clk);
    done_after = a_done; sclk_idle = a_sclk;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs_a: got %b expected 1", a_cs); end
    n_checks++; if ({a_sclk, a_mosi, a_busy, a_done} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl_a: got %b expected 0000", {a_sclk, a_mosi, a_busy, a_done}); end
    n_checks++; if (a_rx !== 8'h00) begin n_fail++; $display("FAIL reset_rx_a: got %h expected 00", a_rx); end
    n_checks++; if (b_cs !== 4'hF || b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_b: got cs %b busy %b expected 1111 0", b_cs, b_busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0;
    run_a(8'b00001001, 2'b00, 8'b01010011);
    n_checks++; if (a_rx !== 8'b01010011) begin n_fail++; $display("FAIL m0_rx: got %b expected 01010011", a_rx); end
    // MOSI order 1,0,0,1,0,0,0,0 -> sa_got[0..7]
    n_checks++; if (sa_got !== 8'b00001001) begin n_fail++; $display("FAIL m0_mosi: got %b expected 00001001", sa_got); end
    n_checks++; if (dc - fb !== 51) begin n_fail++; $display("FAIL m0_latency: got %0d expected 51 (done at accept+52)", dc - fb); end
    n_checks++; if (sa_rise !== 8) begin n_fail++; $display("FAIL m0_rising: got %0d expected 8", sa_rise); end
    n_checks++; if ({sclk_pre, sclk_e1} !== 2'b01) begin n_fail++; $display("FAIL m0_edge1: got %b expected 01", {sclk_pre, sclk_e1}); end
    n_checks++; if (rx_mid !== 8'h00) begin n_fail++; $display("FAIL m0_rx_hold: got %h expected 00", rx_mid); end
    n_checks++; if (done_after !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL m0_done_pulse: got done %b busy %b expected 0 0", done_after, a_busy); end
  endtask

  task automatic test_modes;
    for (int m = 1; m < 4; m++) begin
      run_a(8'b00111100, 2'(m), 8'b10011000);
      n_checks++; if (a_rx !== 8'b10011000) begin n_fail++; $display("FAIL mode%0d_rx: got %b expected 10011000", m, a_rx); end
      n_checks++; if (sa_got !== 8'b00111100) begin n_fail++; $display("FAIL mode%0d_mosi: got %b expected 00111100", m, sa_got); end
      n_checks++; if (sclk_idle !== m[1]) begin n_fail++; $display("FAIL mode%0d_idle: got %b expected %b", m, sclk_idle, m[1]); end
      n_checks++; if ({sclk_pre, sclk_e1} !== {m[1], ~m[1]}) begin n_fail++; $display("FAIL mode%0d_edge1: got %b expected %b", m, {sclk_pre, sclk_e1}, {m[1], ~m[1]}); end
      n_checks++; if (dc - fb !== 51) begin n_fail++; $display("FAIL mode%0d_latency: got %0d expected 51", m, dc - fb); end
    end
  endtask

  task automatic test_multi_slave;
    int   bfb, bdc;
    logic [3:0] cs_low;
    logic seen;
    // Out-of-range index: must be ignored entirely
    b_sel = 3'd5; b_tx = 16'hFFFF; b_start = 1'b1; seen = 1'b0;
    repeat (6) begin @(negedge clk); if (b_busy || b_done || b_cs != 4'hF) seen = 1'b1; end
    b_start = 1'b0;
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL sel_oob: got activity 1 expected 0"); end
    b_sel = 3'd2; b_tx = 16'hA5C3; sb_word = 16'h3C5A; b_start = 1'b1;
    bfb = -1; bdc = -1; cs_low = 4'h0;
    for (int i = 0; i < 300 && bdc < 0; i++) begin
      @(negedge clk);
      cs_low |= ~b_cs;
      if (b_busy && bfb < 0) begin bfb = cyc; b_start = 1'b0; end
      if (b_done) bdc = cyc;
    end
    b_start = 1'b0;
    n_checks++; if (sb_seq !== 16'hA5C3) begin n_fail++; $display("FAIL b_mosi: got %h expected a5c3", sb_seq); end
    n_checks++; if (b_rx !== 16'h3C5A) begin n_fail++; $display("FAIL b_rx: got %h expected 3c5a", b_rx); end
    n_checks++; if (cs_low !== 4'b0100) begin n_fail++; $display("FAIL b_cs: got %b expected 0100", cs_low); end
    n_checks++; if (bdc - bfb !== 99) begin n_fail++; $display("FAIL b_latency: got %0d expected 99", bdc - bfb); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int d1, hi, d2, extra;
    logic [7:0] rx1;
    a_mode = 2'b00; a_tx = 8'h5A; sa_word = 8'hC3; a_start = 1'b1;
    d1 = -1;
    for (int i = 0; i < 200 && d1 < 0; i++) begin @(negedge clk); if (a_done) d1 = cyc; end
    rx1 = a_rx;
    a_tx = 8'h81; sa_word = 8'h66;   // start stays high through the done cycle
    hi = (a_cs == 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (a_cs == 1'b1) hi++; else break; end
    a_start = 1'b0;
    repeat (10) @(negedge clk);
    a_tx = 8'hFF; a_start = 1'b1;    // mid-frame request, must be ignored
    @(negedge clk);
    a_start = 1'b0;
    d2 = -1;
    for (int i = 0; i < 200 && d2 < 0; i++) begin @(negedge clk); if (a_done) d2 = cyc; end
    extra = 0;
    repeat (20) begin @(negedge clk); if (a_busy) extra++; end
    n_checks++; if (rx1 !== 8'hC3) begin n_fail++; $display("FAIL b2b_rx1: got %h expected c3", rx1); end
    n_checks++; if (hi !== 1) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d expected 1", hi); end
    n_checks++; if (a_rx !== 8'h66) begin n_fail++; $display("FAIL b2b_rx2: got %h expected 66", a_rx); end
    n_checks++; if (sa_got !== 8'h81) begin n_fail++; $display("FAIL b2b_mosi2: got %h expected 81", sa_got); end
    n_checks++; if (d1 < 0 || d2 - d1 !== 52) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 52", d2 - d1); end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_midstart: got %0d busy cycles expected 0", extra); end
  endtask

  task automatic test_reset_midframe;
    int rfb, ndone;
    a_mode = 2'b11; a_tx = 8'hFF; sa_word = 8'hA5; a_start = 1'b1; rfb = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_busy && rfb < 0) begin rfb = cyc; a_start = 1'b0; end
      if (rfb >= 0 && cyc == rfb + 21) break;   // edge 7 just occurred
    end
    a_start = 1'b0;
    n_checks++; if ({a_cs, a_sclk, a_mosi} !== 3'b001) begin n_fail++; $display("FAIL rst_pre: got %b expected 001", {a_cs, a_sclk, a_mosi}); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({a_cs, a_sclk, a_mosi, a_busy, a_done} !== 5'b10000) begin n_fail++; $display("FAIL rst_mid: got %b expected 10000", {a_cs, a_sclk, a_mosi, a_busy, a_done}); end
    n_checks++; if (a_rx !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rx: got %h expected 00", a_rx); end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (70) begin @(negedge clk); if (a_done || a_busy) ndone++; end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d expected 0", ndone); end
    run_a(8'b00001001, 2'b00, 8'b01010011);
    n_checks++; if (a_rx !== 8'b01010011) begin n_fail++; $display("FAIL rst_fresh_rx: got %b expected 01010011", a_rx); end
    n_checks++; if (sa_got !== 8'b00001001) begin n_fail++; $display("FAIL rst_fresh_mosi: got %b expected 00001001", sa_got); end
    n_checks++; if (dc - fb !== 51) begin n_fail++; $display("FAIL rst_fresh_latency: got %0d expected 51", dc - fb); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_mode0;
    test_modes;
    test_multi_slave;
    test_back_to_back;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master that drives the same serial interface our SPI slave consumes (SCLK, active-low CS, MOSI, MISO), generated from a single system clock. It generalises the fixed 8-bit, single-slave, mode-0, LSB-first link to configurable word width, clock divider, bit order and slave count, with a runtime-selectable SPI mode (CPOL/CPHA). It sits between a host-side start/done handshake and up to NUM_SLAVES external or on-chip SPI slaves.

## Interface
- DATA_WIDTH, 8, bits per transaction (≥2)
- CLK_DIV, 3, clk cycles per SCLK half-period (≥2)
- LSB_FIRST, 1, 1: bit 0 shifted first on both MOSI and MISO; 0: MSB first
- NUM_SLAVES, 1, number of CS lines (≥1)
- SEL_W, 1, width of slave_sel (≥ clog2(NUM_SLAVES), min 1)

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- start  in  1  transaction request, sampled when busy=0
- slave_sel  in  SEL_W  target slave index, latched on accept
- mode  in  2  {CPOL,CPHA}, latched on accept
- tx_data  in  DATA_WIDTH  word to send, latched on accept
- rx_data  out  DATA_WIDTH  last received word
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- SCLK  out  1  SPI clock
- CS  out  NUM_SLAVES  active-low chip selects, one-hot-low when busy
- MOSI  out  1  serial data out
- MISO  in  1  serial data in

## Operation
- States: IDLE, SETUP, XFER, HOLD. Half-period counter counts CLK_DIV clk cycles; edge counter counts 2·DATA_WIDTH SCLK edges.
- IDLE: accept when start=1 and slave_sel < NUM_SLAVES; latch tx_data, mode, slave_sel; go SETUP. start with slave_sel ≥ NUM_SLAVES is ignored (stay IDLE, no busy, no done). start while busy=1 is ignored.
- SETUP (CLK_DIV cycles): CS[sel]=0, SCLK=CPOL. CPHA=0: first bit on MOSI at SETUP entry.
- XFER: SCLK toggles every CLK_DIV cycles, 2·DATA_WIDTH edges. Odd edges = leading, even = trailing.
  - CPHA=0: sample MISO on leading edges; shift next MOSI bit on trailing edges (except the final one).
  - CPHA=1: drive MOSI bit on leading edges; sample MISO on trailing edges.
- MISO sampled directly in clk domain in the cycle SCLK toggles to the sampling level; no synchroniser (CLK_DIV ≥ 2 guarantees setup).
- Received bits assembled per LSB_FIRST into a shift register; rx_data updated only at transaction end (holds previous word during a transfer).
- HOLD (CLK_DIV cycles after last edge, SCLK=CPOL): then CS all 1, done=1, busy=0, rx_data=assembled word, state IDLE.
- Between transactions: SCLK holds latched CPOL; MOSI holds last driven bit.
- Reset (reset=0 at a posedge, any state incl. mid-transfer): state IDLE, CS all 1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0, latched mode=0. Aborted transfer produces no done.

## Timing
- Accept at posedge T (busy=0, start=1). From T+1: busy=1, CS[sel]=0, done=0.
- Edge k (1..2·DATA_WIDTH) appears at T+1+k·CLK_DIV.
- done=1, busy=0, CS all 1, rx_data valid at T+1+(2·DATA_WIDTH+1)·CLK_DIV; done low the following cycle.
- DATA_WIDTH=8, CLK_DIV=3: 52 clk cycles from accept edge to done; SCLK period 6 clk.
- Back-to-back: start high in the done cycle is accepted; CS high for exactly 1 clk cycle between frames. Slave index may change between frames.
- No combinational path from any input to any output.

## Test plan
- Mode 0, LSB_FIRST=1, W=8, CLK_DIV=3: tx_data=8'b00001001, slave model returns 8'b01010011 -> MOSI sequence 1,0,0,1,0,0,0,0; rx_data=8'b01010011; done exactly 52 cycles after accept; 8 rising edges.
- Modes 1, 2, 3 with tx=8'b00111100, slave returns 8'b10011000 -> correct data both directions; SCLK idle = CPOL; samples on the CPHA-specified edge.
- LSB_FIRST=0, W=16, NUM_SLAVES=4, slave_sel=2, tx=16'hA5C3 -> MOSI MSB first, only CS[2] low; CS[0,1,3] stay 1; slave_sel=5 -> ignored, busy stays 0.
- Back-to-back: start held high through two frames -> CS high exactly 1 cycle between frames; second rx_data correct; start pulsed mid-frame ignored.
- Reset asserted at edge 7 of a mode-3 frame -> next cycle CS all 1, SCLK=0, MOSI=0, busy=0, rx_data=0, no done; fresh mode-0 frame afterwards completes correctly.
